// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - decode stage handshake, writeback and output bus
interface decode_pipe_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [1:0]        ImmSize;
    logic              RegSrc;
    logic              MemRead;
    logic              RegWrite;
    logic              wb_en;
    logic [3:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [DATA_W-1:0] out_imm;
    logic [3:0]        out_dst;
    logic              out_memread;
    logic              out_regwrite;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output in_valid, instr, ImmSize, RegSrc, MemRead, RegWrite,
               wb_en, wb_reg, wb_data, flush, ex_ready,
        input  in_ready, out_valid, out_rd1, out_rd2, out_imm, out_dst,
               out_memread, out_regwrite, bubble_cnt
    );

    modport slave (
        input  in_valid, instr, ImmSize, RegSrc, MemRead, RegWrite,
               wb_en, wb_reg, wb_data, flush, ex_ready,
        output in_ready, out_valid, out_rd1, out_rd2, out_imm, out_dst,
               out_memread, out_regwrite, bubble_cnt
    );
endinterface

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage with register file, immediates and load-use stall
module decode_pipe #(
    parameter int DATA_W  = 16,
    parameter int ZERO_R0 = 0,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    decode_pipe_if.slave bus
);
    localparam logic [1:0] IMM4 = 2'b00;
    localparam logic [1:0] IMM9 = 2'b01;
    localparam logic [1:0] LLB  = 2'b10;
    localparam logic [1:0] LHB  = 2'b11;
    localparam bit         ZR   = (ZERO_R0 != 0);

    logic [DATA_W-1:0] regs [16];
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              wr_hit;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic [DATA_W-1:0] imm_data;
    logic [DATA_W-1:0] refresh_imm;
    logic              hazard;
    logic              accept;
    logic [3:0]        held_src1;
    logic [3:0]        held_src2;
    logic [1:0]        held_imm_size;
    logic [7:0]        held_lo;
    logic              unused_instr_hi;

    assign src1            = bus.instr[7:4];
    assign src2            = bus.RegSrc ? bus.instr[11:8] : bus.instr[3:0];
    // a write to R0 is dropped entirely when R0 is hardwired to zero
    assign wr_hit          = bus.wb_en && !(ZR && bus.wb_reg == 4'd0);
    assign unused_instr_hi = ^bus.instr[15:12];

    // combinational operand read with same-cycle writeback bypass
    always_comb begin
        rd1_data = regs[src1];
        rd2_data = regs[src2];
        if (wr_hit && bus.wb_reg == src1) rd1_data = bus.wb_data;
        if (wr_hit && bus.wb_reg == src2) rd2_data = bus.wb_data;
        if (ZR && src1 == 4'd0) rd1_data = '0;
        if (ZR && src2 == 4'd0) rd2_data = '0;
    end

    // immediate formatting; LLB/LHB merge the instruction byte into src2 data
    always_comb begin
        imm_data = '0;
        unique case (bus.ImmSize)
            IMM4: imm_data = {{(DATA_W-4){bus.instr[3]}}, bus.instr[3:0]};
            IMM9: imm_data = {{(DATA_W-9){bus.instr[8]}}, bus.instr[8:0]};
            LLB: begin
                imm_data       = rd2_data;
                imm_data[7:0]  = bus.instr[7:0];
            end
            default: begin
                imm_data       = rd2_data;
                imm_data[15:8] = bus.instr[7:0];
            end
        endcase
    end

    // LLB/LHB immediate rebuilt from a writeback landing on the held src2
    always_comb begin
        refresh_imm = bus.wb_data;
        if (held_imm_size == LHB) refresh_imm[15:8] = held_lo;
        else                      refresh_imm[7:0]  = held_lo;
    end

    // a held load whose destination feeds this instruction forces a bubble
    assign hazard = bus.out_valid && bus.out_memread && bus.out_regwrite &&
                    (bus.out_dst == src1 || bus.out_dst == src2) &&
                    !(ZR && bus.out_dst == 4'd0);

    assign bus.in_ready = (!bus.out_valid || bus.ex_ready) && !hazard &&
                          !bus.flush && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // register file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[bus.wb_reg] <= bus.wb_data;
        end
    end

    // output register: flush, load, drain, or hold with operand refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_rd1      <= '0;
            bus.out_rd2      <= '0;
            bus.out_imm      <= '0;
            bus.out_dst      <= '0;
            bus.out_memread  <= 1'b0;
            bus.out_regwrite <= 1'b0;
            held_src1        <= '0;
            held_src2        <= '0;
            held_imm_size    <= '0;
            held_lo          <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.out_rd1      <= rd1_data;
            bus.out_rd2      <= rd2_data;
            bus.out_imm      <= imm_data;
            bus.out_dst      <= bus.instr[11:8];
            bus.out_memread  <= bus.MemRead;
            bus.out_regwrite <= bus.RegWrite;
            held_src1        <= src1;
            held_src2        <= src2;
            held_imm_size    <= bus.ImmSize;
            held_lo          <= bus.instr[7:0];
        end else if (bus.out_valid && bus.ex_ready) begin
            bus.out_valid <= 1'b0;
        end else if (bus.out_valid) begin
            if (wr_hit && bus.wb_reg == held_src1) bus.out_rd1 <= bus.wb_data;
            if (wr_hit && bus.wb_reg == held_src2) begin
                bus.out_rd2 <= bus.wb_data;
                if (held_imm_size == LLB || held_imm_size == LHB)
                    bus.out_imm <= refresh_imm;
            end
        end
    end

    // saturating count of load-use bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bubble_cnt <= '0;
        end else if (bus.in_valid && bus.ex_ready && hazard &&
                     bus.bubble_cnt != {CNT_W{1'b1}}) begin
            bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register and operand width (minimum 16).
REQ-002 The block SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads as zero and writes to it are discarded.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the bubble counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block accepts instruction this cycle
- instr  in  16  instruction: rd [11:8], rs1 [7:4], rs2 [3:0]
- ImmSize  in  2  00 imm4 sext; 01 imm9 sext; 10 LLB; 11 LHB
- RegSrc  in  1  1: second source = instr[11:8]; 0: instr[3:0]
- MemRead  in  1  instruction is a load
- RegWrite  in  1  instruction writes rd
- wb_en  in  1  writeback enable
- wb_reg  in  4  writeback register index
- wb_data  in  DATA_W  writeback data
- flush  in  1  discard the held instruction
- ex_ready  in  1  downstream accepts out_* this cycle
- out_valid  out  1  out_* holds a valid decoded instruction
- out_rd1, out_rd2  out  DATA_W each  source operands
- out_imm  out  DATA_W  formatted immediate
- out_dst  out  4  destination index
- out_memread, out_regwrite  out  1 each  registered control bits
- bubble_cnt  out  CNT_W  count of inserted load-use bubbles

Function
REQ-006 The block SHALL contain 16 registers of DATA_W bits, written at the clock edge when wb_en=1 (with wb_reg=0 excluded when ZERO_R0=1).
REQ-007 Reads SHALL be combinational with write bypass: if wb_en=1 and wb_reg equals the read index, the read returns wb_data.
REQ-008 src1 SHALL be instr[7:4]; src2 SHALL be instr[11:8] when RegSrc=1, else instr[3:0].
REQ-009 The immediate SHALL be formed as follows:
- imm4: instr[3:0] sign-extended to DATA_W.
- imm9: instr[8:0] sign-extended to DATA_W.
- LLB: src2 data with bits [7:0] replaced by instr[7:0].
- LHB: src2 data with bits [15:8] replaced by instr[7:0].
- LLB and LHB both keep bits above 15 from src2.
REQ-010 The hazard signal SHALL be 1 when all of the following hold: out_valid=1, out_memread=1, out_regwrite=1, out_dst equals src1 or src2, and it is not the case that ZERO_R0=1 with out_dst=0.
REQ-011 in_ready SHALL equal (!out_valid | ex_ready) & !hazard & !flush.
REQ-012 The output register behaviour SHALL be:
- Load: on in_valid & in_ready, the output register SHALL capture decoded operands, imm, rd, MemRead and RegWrite, and set out_valid=1 on the next edge.
- Drain: when out_valid & ex_ready and no new instruction is accepted, out_valid SHALL go to 0.
- Bubble: on ex_ready & hazard & in_valid, the held load drains, out_valid SHALL go to 0 for exactly one cycle, and bubble_cnt SHALL increment.
- Resume: the stalled instruction SHALL be accepted on the following cycle, one cycle of load-use latency.
REQ-013 Hold: while out_valid=1 and ex_ready=0, all out_* SHALL be stable, except as REQ-014 allows.
REQ-014 Held-operand refresh: while holding, a wb_en write whose index matches the held instruction's src1 or src2 SHALL update out_rd1 or out_rd2 (and the LLB/LHB-derived out_imm) at that edge.
REQ-015 Latency: an accepted instruction SHALL appear on out_* one cycle later.
REQ-016 flush=1 SHALL clear out_valid at the next edge, with priority over load, and SHALL NOT block register writeback.
REQ-017 bubble_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 Simultaneous writeback to, and decode of, the same register SHALL yield the new value (bypass).

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL clear all 16 registers to 0, out_valid to 0, all out_* data and control to 0, and bubble_cnt to 0.
REQ-020 Reset SHALL override flush, load and writeback in the same cycle; in_ready SHALL read 0 during reset.
REQ-021 Reset asserted mid-stall SHALL discard the held instruction; no bubble is counted.

Verification
REQ-022 Writeback then read: wb R3=0x1234, then decode instr=0x0135 with imm4 -> out_rd1=R3=0x1234 one cycle after accept; out_imm=0x0005.
REQ-023 Bypass: wb_en R5=0xBEEF in the same cycle as decoding rs2=R5 -> out_rd2=0xBEEF.
REQ-024 Load-use: load with rd=R2 held, next instruction has rs1=R2, ex_ready=1 -> in_ready=0 for one cycle, out_valid=0 for one cycle, bubble_cnt=1, then the instruction issues.
REQ-025 Immediates: R4=0xAAAA with LLB imm 0x5C -> out_imm=0xAA5C; with LHB -> 0x5CAA; imm9 0x1F0 -> 0xFFF0.
REQ-026 Hold and refresh: ex_ready=0 with the held instruction reading R7, then wb R7=0x0042 -> out_rd1=0x0042 and the other outputs are unchanged.
REQ-027 Flush and reset: flush with in_valid=1 -> out_valid=0 and no accept; rst mid-stall -> all outputs and bubble_cnt are 0; with ZERO_R0=1, a write to R0 of 0xFFFF -> R0 reads 0.
